// File: rtl/riscv_mc_core.sv
// riscv_mc_core: multi-cycle RV32I-subset core, one instruction in flight.
// Define RISCV_MC_MUL_EN to add the MUL instruction.
module riscv_mc_core #(
    parameter int XLEN = 32,
    parameter int NREGS = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            retire,
    output logic            halted,
    output logic [XLEN-1:0] pc
);
    localparam int RW = $clog2(NREGS);
    localparam int SH = $clog2(XLEN);

    typedef enum logic [2:0] {
        BOOT, FETCH, EXEC, MEM, WB, HALT
    } state_t;

    state_t state, state_n;

    logic [31:0]     ir;
    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] res, npc, sdata;
    logic            wen, st_op;

    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;

    assign op  = ir[6:0];
    assign rd  = ir[11:7];
    assign f3  = ir[14:12];
    assign rs1 = ir[19:15];
    assign rs2 = ir[24:20];
    assign f7  = ir[31:25];

    logic signed [11:0] si, ss;
    logic signed [12:0] sb;
    logic signed [20:0] sj;
    logic signed [31:0] su;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;

    assign si = ir[31:20];
    assign ss = {ir[31:25], ir[11:7]};
    assign sb = {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign sj = {ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign su = {ir[31:12], 12'b0};
    assign imm_i = XLEN'(si);
    assign imm_s = XLEN'(ss);
    assign imm_b = XLEN'(sb);
    assign imm_j = XLEN'(sj);
    assign imm_u = XLEN'(su);

    logic [XLEN-1:0] a, b;
    logic [SH-1:0]   shamt;
    logic            lt;

    assign a = (rs1 == 5'd0) ? '0 : regs[rs1[RW-1:0]];
    assign b = (rs2 == 5'd0) ? '0 : regs[rs2[RW-1:0]];
    assign shamt = b[SH-1:0];
    assign lt = $signed(a) < $signed(b);

    logic is_op, is_opi, is_ld, is_st, is_br, is_lui, is_jal;

    assign is_op  = op == 7'b0110011;
    assign is_opi = op == 7'b0010011;
    assign is_ld  = op == 7'b0000011;
    assign is_st  = op == 7'b0100011;
    assign is_br  = op == 7'b1100011;
    assign is_lui = op == 7'b0110111;
    assign is_jal = op == 7'b1101111;

    logic            legal, u1, u2, ud, taken, fault;
    logic [XLEN-1:0] result, target;

    always_comb begin
        legal  = 1'b0;
        u1     = 1'b0;
        u2     = 1'b0;
        ud     = 1'b0;
        taken  = 1'b0;
        result = '0;
        target = pc + imm_b;
        unique case (1'b1)
            is_op: begin
                {legal, u1, u2, ud} = 4'b1111;
                case ({f7, f3})
                    {7'h00, 3'd0}: result = a + b;
                    {7'h20, 3'd0}: result = a - b;
                    {7'h00, 3'd1}: result = a << shamt;
                    {7'h00, 3'd2}: result = {{(XLEN-1){1'b0}}, lt};
                    {7'h00, 3'd4}: result = a ^ b;
                    {7'h00, 3'd5}: result = a >> shamt;
                    {7'h00, 3'd6}: result = a | b;
                    {7'h00, 3'd7}: result = a & b;
`ifdef RISCV_MC_MUL_EN
                    {7'h01, 3'd0}: result = a * b;
`endif
                    default: legal = 1'b0;
                endcase
            end
            is_opi: begin
                {u1, ud} = 2'b11;
                legal  = f3 == 3'd0;
                result = a + imm_i;
            end
            is_ld: begin
                {u1, ud} = 2'b11;
                legal  = f3 == 3'd2;
                result = a + imm_i;
            end
            is_st: begin
                {u1, u2} = 2'b11;
                legal  = f3 == 3'd2;
                result = a + imm_s;
            end
            is_br: begin
                {legal, u1, u2} = 3'b111;
                case (f3)
                    3'd0: taken = a == b;
                    3'd1: taken = a != b;
                    3'd4: taken = lt;
                    3'd5: taken = !lt;
                    default: legal = 1'b0;
                endcase
            end
            is_lui: begin
                {legal, ud} = 2'b11;
                result = imm_u;
            end
            is_jal: begin
                {legal, ud, taken} = 3'b111;
                result = pc + XLEN'(4);
                target = pc + imm_j;
            end
            default: ;
        endcase
    end

    // Out-of-range register indices and misaligned jumps stop the core.
    assign fault = !legal
        || (u1 && 32'(rs1) >= NREGS)
        || (u2 && 32'(rs2) >= NREGS)
        || (ud && 32'(rd) >= NREGS)
        || (taken && target[1:0] != 2'b00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= BOOT;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        retire   = 1'b0;
        halted   = 1'b0;
        unique case (state)
            BOOT:  state_n = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) state_n = EXEC;
            end
            EXEC: begin
                if (fault)              state_n = HALT;
                else if (is_ld || is_st) state_n = MEM;
                else                    state_n = WB;
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = st_op;
                if (dmem_ready) state_n = WB;
            end
            WB: begin
                retire  = 1'b1;
                state_n = FETCH;
            end
            HALT:    halted = 1'b1;
            default: state_n = HALT;
        endcase
    end

    assign imem_addr  = pc;
    assign dmem_addr  = res;
    assign dmem_wdata = sdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc    <= RESET_PC;
            ir    <= '0;
            res   <= '0;
            npc   <= '0;
            sdata <= '0;
            wen   <= 1'b0;
            st_op <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            unique case (state)
                FETCH: if (imem_ready) ir <= imem_rdata;
                EXEC: begin
                    res   <= result;
                    npc   <= taken ? target : pc + XLEN'(4);
                    sdata <= b;
                    wen   <= ud;
                    st_op <= is_st;
                end
                MEM: if (dmem_ready && !st_op) res <= dmem_rdata;
                WB: begin
                    pc <= npc;
                    if (wen && rd != 5'd0) regs[rd[RW-1:0]] <= res;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_mc_core.sv
// Directed testbench for riscv_mc_core: small programs, store-log checks.
// Memory responders answer with a programmable number of wait cycles.
module tb_riscv_mc_core;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req, imem_ready;
    logic [31:0] imem_addr, imem_rdata;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        retire, halted;
    logic [31:0] pc;

    riscv_mc_core dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .retire(retire), .halted(halted), .pc(pc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [31:0] imem [64];
    logic [31:0] dmem [64];
    int ilat = 0, dlat = 0, iw = 0, dw = 0;
    int rt_q[$];
    int dl_q[$];
    bit ds_q[$];
    logic [31:0] fa_q[$], wa_q[$], wd_q[$];
    logic [31:0] da0, dd0;
    bit stab;

    initial begin
        imem_ready = 1'b0;
        imem_rdata = '0;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (retire) rt_q.push_back(cyc);
            if (imem_req && reset) begin
                if (iw >= ilat) begin
                    imem_ready = 1'b1;
                    imem_rdata = imem[imem_addr[7:2]];
                    fa_q.push_back(imem_addr);
                end else begin
                    imem_ready = 1'b0;
                end
                iw++;
            end else begin
                imem_ready = 1'b0;
                iw = 0;
            end
            if (dmem_req && reset) begin
                if (dw == 0) begin
                    da0 = dmem_addr;
                    dd0 = dmem_wdata;
                    stab = 1'b1;
                end else if (dmem_addr !== da0 || dmem_wdata !== dd0) begin
                    stab = 1'b0;
                end
                if (dw >= dlat) begin
                    dmem_ready = 1'b1;
                    if (dmem_we) begin
                        dmem[dmem_addr[7:2]] = dmem_wdata;
                        wa_q.push_back(dmem_addr);
                        wd_q.push_back(dmem_wdata);
                    end else begin
                        dmem_rdata = dmem[dmem_addr[7:2]];
                    end
                    dl_q.push_back(dw + 1);
                    ds_q.push_back(stab);
                end else begin
                    dmem_ready = 1'b0;
                end
                dw++;
            end else begin
                dmem_ready = 1'b0;
                dw = 0;
            end
        end
    end

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        logic [31:0] im;
        im = imm;
        return {im[11:0], 5'(rs1), 3'd0, 5'(rd), 7'h13};
    endfunction

    function automatic logic [31:0] lw(input int rd, input int rs1, input int imm);
        logic [31:0] im;
        im = imm;
        return {im[11:0], 5'(rs1), 3'd2, 5'(rd), 7'h03};
    endfunction

    function automatic logic [31:0] sw(input int rs2, input int rs1, input int imm);
        logic [31:0] im;
        im = imm;
        return {im[11:5], 5'(rs2), 5'(rs1), 3'd2, im[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] rtype(input int f7, input int f3, input int rd,
                                          input int rs1, input int rs2);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] br(input int f3, input int rs1, input int rs2, input int imm);
        logic [31:0] im;
        im = imm;
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] lui(input int rd, input int imm20);
        return {20'(imm20), 5'(rd), 7'h37};
    endfunction

    function automatic logic [31:0] jal(input int rd, input int imm);
        logic [31:0] im;
        im = imm;
        return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'h6f};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0000_007F;
    endtask

    task automatic start(input int il, input int dl);
        ilat = il;
        dlat = dl;
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #2;
        rt_q.delete();
        fa_q.delete();
        wa_q.delete();
        wd_q.delete();
        dl_q.delete();
        ds_q.delete();
        reset = 1'b1;
    endtask

    task automatic wait_halt(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (halted) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({imem_req, dmem_req, dmem_we, retire, halted} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outs: got %b want 00000",
                     {imem_req, dmem_req, dmem_we, retire, halted});
        end
        checks++;
        if (pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc: got %h want 00000000", pc);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL boot_noreq: got %b want 0", imem_req);
        end
        @(posedge clk);
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL first_fetch: req %b addr %h want 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_addi();
        bit ok;
        clear_imem();
        imem[0] = addi(1, 0, 5);
        imem[1] = addi(2, 1, -7);
        imem[2] = sw(2, 0, 16);
        start(0, 0);
        wait_halt(100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL addi_halt: got %b want 1", ok);
        end
        checks++;
        if (rt_q.size() != 3) begin
            errors++;
            $display("FAIL addi_retires: got %0d want 3", rt_q.size());
        end else begin
            checks++;
            if (rt_q[1] - rt_q[0] != 3) begin
                errors++;
                $display("FAIL addi_gap: got %0d want 3", rt_q[1] - rt_q[0]);
            end
        end
        checks++;
        if (wd_q.size() != 1 || wd_q[0] !== 32'hFFFF_FFFE || wa_q[0] !== 32'd16) begin
            errors++;
            $display("FAIL addi_x2: got n=%0d want FFFFFFFE at 16", wd_q.size());
        end
    endtask

    task automatic test_sw_lw();
        bit ok;
        clear_imem();
        imem[0] = addi(1, 0, 5);
        imem[1] = addi(2, 1, -7);
        imem[2] = sw(2, 0, 8);
        imem[3] = lw(3, 0, 8);
        imem[4] = sw(3, 0, 12);
        start(0, 3);
        wait_halt(200, ok);
        checks++;
        if (!ok || rt_q.size() != 5) begin
            errors++;
            $display("FAIL swlw_retires: got %0d want 5", rt_q.size());
        end else begin
            checks++;
            if (rt_q[2] - rt_q[1] != 7) begin
                errors++;
                $display("FAIL sw_latency: got %0d want 7", rt_q[2] - rt_q[1]);
            end
        end
        checks++;
        if (dl_q.size() != 3 || dl_q[0] != 4 || ds_q[0] !== 1'b1) begin
            errors++;
            $display("FAIL sw_hold: got n=%0d want 4 stable cycles", dl_q.size());
        end
        checks++;
        if (wd_q.size() != 2) begin
            errors++;
            $display("FAIL swlw_writes: got %0d want 2", wd_q.size());
        end else begin
            checks++;
            if (wa_q[0] !== 32'd8 || wd_q[0] !== 32'hFFFF_FFFE) begin
                errors++;
                $display("FAIL sw_data: got %h@%h want FFFFFFFE@8", wd_q[0], wa_q[0]);
            end
            checks++;
            if (wa_q[1] !== 32'd12 || wd_q[1] !== 32'hFFFF_FFFE) begin
                errors++;
                $display("FAIL lw_x3: got %h@%h want FFFFFFFE@c", wd_q[1], wa_q[1]);
            end
        end
    endtask

    task automatic test_branch();
        bit ok;
        clear_imem();
        imem[0] = addi(1, 0, 2);
        imem[1] = addi(7, 0, 0);
        imem[2] = addi(1, 1, -1);
        imem[3] = addi(7, 7, 3);
        imem[4] = br(1, 1, 0, -8);
        imem[5] = sw(7, 0, 0);
        start(1, 0);
        wait_halt(300, ok);
        checks++;
        if (!ok || fa_q.size() != 10) begin
            errors++;
            $display("FAIL bne_fetches: got %0d want 10", fa_q.size());
        end else begin
            checks++;
            if (fa_q[5] !== 32'h08) begin
                errors++;
                $display("FAIL bne_taken: got %h want 00000008", fa_q[5]);
            end
            checks++;
            if (fa_q[8] !== 32'h14) begin
                errors++;
                $display("FAIL bne_fall: got %h want 00000014", fa_q[8]);
            end
        end
        checks++;
        if (wd_q.size() != 1 || wd_q[0] !== 32'd6) begin
            errors++;
            $display("FAIL bne_loop: got n=%0d want 6", wd_q.size());
        end
        clear_imem();
        imem[0] = addi(1, 0, 5);
        imem[1] = addi(0, 0, 0);
        imem[2] = addi(0, 0, 0);
        imem[3] = addi(0, 0, 0);
        imem[4] = br(0, 1, 0, -8);
        imem[5] = sw(1, 0, 0);
        start(0, 0);
        wait_halt(200, ok);
        checks++;
        if (!ok || fa_q.size() != 7 || fa_q[5] !== 32'h14) begin
            errors++;
            $display("FAIL beq_fall: got n=%0d want next fetch 00000014", fa_q.size());
        end
    endtask

    task automatic test_alu();
        bit ok;
        logic [31:0] got;
        logic [31:0] exp [9];
        exp = '{32'd7, 32'd1, 32'h07FF_FFFF, 32'hFFFF_FFFB, 32'd4,
                32'hA0, 32'h8000_0000, 32'h28, 32'd0};
        clear_imem();
        imem[0]  = addi(1, 0, 5);
        imem[1]  = addi(2, 0, -2);
        imem[2]  = rtype(32, 0, 3, 1, 2);
        imem[3]  = rtype(0, 2, 4, 2, 1);
        imem[4]  = rtype(0, 5, 5, 2, 1);
        imem[5]  = rtype(0, 4, 6, 1, 2);
        imem[6]  = rtype(0, 7, 7, 1, 2);
        imem[7]  = rtype(0, 1, 10, 1, 1);
        imem[8]  = lui(8, 32'h80000);
        imem[9]  = jal(9, 8);
        imem[11] = sw(3, 0, 0);
        imem[12] = sw(4, 0, 4);
        imem[13] = sw(5, 0, 8);
        imem[14] = sw(6, 0, 12);
        imem[15] = sw(7, 0, 16);
        imem[16] = sw(10, 0, 20);
        imem[17] = sw(8, 0, 24);
        imem[18] = sw(9, 0, 28);
        imem[19] = addi(0, 0, 9);
        imem[20] = sw(0, 0, 32);
        start(0, 0);
        wait_halt(400, ok);
        checks++;
        if (!ok || rt_q.size() != 20) begin
            errors++;
            $display("FAIL alu_retires: got %0d want 20", rt_q.size());
        end
        for (int k = 0; k < 9; k++) begin
            got = (k < wd_q.size()) ? wd_q[k] : 32'hxxxx_xxxx;
            checks++;
            if (got !== exp[k]) begin
                errors++;
                $display("FAIL alu_store%0d: got %h want %h", k, got, exp[k]);
            end
        end
    endtask

    task automatic test_halt();
        bit ok;
        int reqs, rets;
        clear_imem();
        start(0, 0);
        wait_halt(50, ok);
        checks++;
        if (!ok || rt_q.size() != 0) begin
            errors++;
            $display("FAIL illegal_halt: halted %b retires %0d want 1 0", ok, rt_q.size());
        end
        reqs = 0;
        rets = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req || dmem_req) reqs++;
            if (retire || !halted) rets++;
        end
        checks++;
        if (reqs != 0 || rets != 0) begin
            errors++;
            $display("FAIL halt_hold: reqs %0d bad %0d want 0 0", reqs, rets);
        end
        start(0, 0);
        #1;
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_clear: got %b want 0", halted);
        end
        @(posedge clk);
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL halt_refetch: req %b addr %h want 1 00000000", imem_req, imem_addr);
        end
        imem[0] = addi(1, 0, 1);
        imem[1] = jal(0, 6);
        start(0, 0);
        wait_halt(50, ok);
        checks++;
        if (!ok || rt_q.size() != 1) begin
            errors++;
            $display("FAIL misalign_halt: halted %b retires %0d want 1 1", ok, rt_q.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_imem();
        start(10, 0);
        @(posedge clk);
        #2;
        checks++;
        if (imem_req !== 1'b1 || imem_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_setup: req %b ready %b want 1 0", imem_req, imem_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL mid_drop: got %b want 0", imem_req);
        end
        ilat = 0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL mid_boot: got %b want 0", imem_req);
        end
        @(posedge clk);
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL mid_refetch: req %b addr %h want 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_mul();
        bit ok;
        clear_imem();
        imem[0] = addi(1, 0, 5);
        imem[1] = addi(2, 0, -2);
        imem[2] = rtype(1, 0, 4, 1, 2);
        imem[3] = sw(4, 0, 0);
        start(0, 0);
        wait_halt(100, ok);
`ifdef RISCV_MC_MUL_EN
        checks++;
        if (!ok || rt_q.size() != 4 || rt_q[2] - rt_q[1] != 3) begin
            errors++;
            $display("FAIL mul_retire: got %0d retires want 4, gap 3", rt_q.size());
        end
        checks++;
        if (wd_q.size() != 1 || wd_q[0] !== 32'hFFFF_FFF6) begin
            errors++;
            $display("FAIL mul_x4: got n=%0d want FFFFFFF6", wd_q.size());
        end
`else
        checks++;
        if (!ok || rt_q.size() != 2 || wd_q.size() != 0) begin
            errors++;
            $display("FAIL mul_illegal: halted %b retires %0d want 1 2", ok, rt_q.size());
        end
`endif
    endtask

    initial begin
        clear_imem();
        for (int i = 0; i < 64; i++) dmem[i] = '0;
        test_reset();
        test_addi();
        test_sw_lw();
        test_branch();
        test_alu();
        test_halt();
        test_reset_mid();
        test_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/riscv_mc_core.md
RISCV_MC_CORE -- requirements
Module: riscv_mc_core

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath and register width (32 or 64).
REQ-002 SHALL have parameter NREGS, default 32: register count (16 or 32); x0 reads 0.
REQ-003 SHALL have parameter RESET_PC, default 0: first fetch address.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have ports imem_req out 1, imem_addr out XLEN, imem_ready in 1, imem_rdata in 32: instruction fetch channel.
REQ-007 SHALL have ports dmem_req out 1, dmem_we out 1, dmem_addr out XLEN, dmem_wdata out XLEN, dmem_ready in 1, dmem_rdata in XLEN: data channel.
REQ-008 SHALL have ports retire out 1 (one-cycle pulse per completed instruction), halted out 1, pc out XLEN (current instruction address).

Function
REQ-009 SHALL sequence states BOOT, FETCH, EXEC, MEM, WB, HALT; BOOT lasts one cycle after reset release, then FETCH.
REQ-010 SHALL, in both channels, hold req, addr, we and wdata stable until ready is high; transfer completes on the edge where req&&ready; req SHALL drop the next cycle; ready may be high in the same cycle req rises.
REQ-011 SHALL, in FETCH, drive imem_req=1, imem_addr=pc; on completion latch imem_rdata into the instruction register and go to EXEC.
REQ-012 SHALL, in EXEC, decode, read rs1/rs2 and compute the result; LW/SW go to MEM, all others go to WB.
REQ-013 SHALL support ADD SUB AND OR XOR SLL SRL SLT ADDI LW SW BEQ BNE BLT BGE LUI JAL with RV32I encodings; BLT/BGE/SLT are signed.
REQ-014 SHALL wrap arithmetic modulo 2^XLEN; shifts use the low log2(XLEN) bits of rs2; immediates are sign-extended to XLEN; LUI yields imm[31:12]<<12, sign-extended.
REQ-015 SHALL, in MEM, issue dmem_addr=rs1+imm; SW drives dmem_we=1 and dmem_wdata=rs2; LW drives dmem_we=0 and captures dmem_rdata.
REQ-016 SHALL, in WB, write rd (writes to x0 discarded), set pc to pc+imm for a taken branch or JAL and pc+4 otherwise, pulse retire, and return to FETCH; JAL writes pc+4 to rd.
REQ-017 SHALL complete ALU/branch/LUI/JAL in 3 cycles and LW/SW in 4 cycles with zero-wait memory; each wait cycle adds 1.
REQ-018 SHALL enter HALT without retiring on an unknown opcode/funct, a register index >= NREGS, or a taken target with bits[1:0] != 0.
REQ-019 SHALL, in HALT, hold halted=1 and issue no requests until reset.

Reset
REQ-020 SHALL, while reset=0, force imem_req=0, dmem_req=0, dmem_we=0, retire=0, halted=0, pc=RESET_PC, all registers 0, state BOOT, asynchronously.
REQ-021 SHALL, on reset mid-transaction, drop the pending req immediately and ignore any ready seen later; the first fetch after release is at RESET_PC.

Configuration
REQ-022 SHALL, with RISCV_MC_MUL_EN defined, execute MUL (opcode 0110011, funct7 0000001, funct3 000) as the low XLEN bits of rs1*rs2 in 3 cycles.
REQ-023 SHALL, without RISCV_MC_MUL_EN, treat MUL as illegal (HALT).

Verification
REQ-024 SHALL verify: ADDI x1,x0,5; ADDI x2,x1,-7 with zero-wait imem -> x2=0xFFFFFFFE, two retire pulses 3 cycles apart.
REQ-025 SHALL verify: SW x2,8(x0) with dmem_ready delayed 3 cycles -> dmem_req/addr=8/wdata=0xFFFFFFFE stable 4 cycles; LW x3,8(x0) -> x3=0xFFFFFFFE.
REQ-026 SHALL verify: BNE x1,x0,-8 at pc 0x10 -> next imem_addr=0x08; BEQ x1,x0,-8 at pc 0x10 -> next imem_addr=0x14.
REQ-027 SHALL verify: fetch of 0x0000007F -> halted=1, retire=0, no imem_req for 20 cycles; after a reset pulse -> fetch at RESET_PC, halted=0.
REQ-028 SHALL verify: reset=0 while imem_req=1 and imem_ready=0 -> imem_req=0 the same cycle; after release, BOOT then imem_addr=RESET_PC.
REQ-029 SHALL verify: MUL x4,x1,x2 (x1=5, x2=-2) -> x4=0xFFFFFFF6 with RISCV_MC_MUL_EN; halted=1 without it.
